// File: rtl/network_source.sv
// Source-side dispatch: folds a count word plus that many spike indices into one
// parallel input vector, then offers it to the network with a valid/ready handshake.
module network_source #(
    parameter int NUM_INP   = 4,
    parameter int SRC_WIDTH = $clog2(NUM_INP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [SRC_WIDTH-1:0] src,
    output logic                 net_valid,
    input  logic                 net_ready,
    output logic [NUM_INP-1:0]   net_inp,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_COUNT,
        S_COLLECT,
        S_DISPATCH
    } state_t;

    localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NUM_INP);
    localparam logic [SRC_WIDTH-1:0] ONE_W     = SRC_WIDTH'(1);

    state_t                 r_state;
    logic [NUM_INP-1:0]     r_net_inp;
    logic [SRC_WIDTH-1:0]   r_remaining;
    logic                   r_err;

    state_t                 w_state_next;
    logic [NUM_INP-1:0]     w_inp_next;
    logic [SRC_WIDTH-1:0]   w_rem_next;
    logic                   w_err_next;
    logic                   w_src_beat;
    logic                   w_net_beat;

    assign src_ready  = (r_state != S_DISPATCH) && !rst;
    assign net_valid  = (r_state == S_DISPATCH);
    assign net_inp    = r_net_inp;
    assign err        = r_err;
    assign w_src_beat = src_valid && src_ready;
    assign w_net_beat = net_valid && net_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COUNT;
            r_net_inp   <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_net_inp   <= w_inp_next;
            r_remaining <= w_rem_next;
            r_err       <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_inp_next   = r_net_inp;
        w_rem_next   = r_remaining;
        w_err_next   = r_err;
        case (r_state)
            S_COUNT: begin
                if (w_src_beat) begin
                    if (src == '0) begin
                        w_state_next = S_DISPATCH;
                    end else if (src <= NUM_INP_W) begin
                        w_rem_next   = src;
                        w_state_next = S_COLLECT;
                    end else begin
                        // Oversized count saturates so the run still terminates.
                        w_err_next   = 1'b1;
                        w_rem_next   = NUM_INP_W;
                        w_state_next = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (w_src_beat) begin
                    if (src < NUM_INP_W) begin
                        for (int i = 0; i < NUM_INP; i++) begin
                            if (src == SRC_WIDTH'(i)) begin
                                w_inp_next[i] = 1'b1;
                            end
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
                    w_rem_next = r_remaining - ONE_W;
                    if (r_remaining == ONE_W) begin
                        w_state_next = S_DISPATCH;
                    end
                end
            end
            S_DISPATCH: begin
                if (w_net_beat) begin
                    w_inp_next   = '0;
                    w_state_next = S_COUNT;
                end
            end
            default: begin
                w_state_next = S_COUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_network_source.sv
// Directed bench for network_source with NUM_INP=4: hand-computed vectors for
// normal runs, empty runs, backpressure, protocol errors and mid-run reset.
module tb_network_source;

    localparam int NUM_INP   = 4;
    localparam int SRC_WIDTH = 3;

    logic                 clk;
    logic                 rst;
    logic                 src_valid;
    logic                 src_ready;
    logic [SRC_WIDTH-1:0] src;
    logic                 net_valid;
    logic                 net_ready;
    logic [NUM_INP-1:0]   net_inp;
    logic                 err;

    int total;
    int bad;

    network_source #(
        .NUM_INP   (NUM_INP),
        .SRC_WIDTH (SRC_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src       (src),
        .net_valid (net_valid),
        .net_ready (net_ready),
        .net_inp   (net_inp),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and outputs settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one source word for exactly one edge.
    task automatic applyStimulus(input logic [SRC_WIDTH-1:0] word);
        src_valid = 1'b1;
        src       = word;
        step();
        src_valid = 1'b0;
        src       = '0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        src_valid = 1'b0;
        src       = '0;
        net_ready = 1'b1;
        #1;
        checkOutput("rst_src_ready", 8'(src_ready), 8'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("reset_net_valid", 8'(net_valid), 8'd0);
        checkOutput("reset_net_inp", 8'(net_inp), 8'h0);
        checkOutput("reset_err", 8'(err), 8'd0);
        checkOutput("reset_src_ready", 8'(src_ready), 8'd1);

        // Basic run: count 2, indices 3 and 1.
        applyStimulus(3'd2);
        applyStimulus(3'd3);
        checkOutput("basic_partial_inp", 8'(net_inp), 8'h8);
        checkOutput("basic_not_yet_valid", 8'(net_valid), 8'd0);
        applyStimulus(3'd1);
        checkOutput("basic_valid", 8'(net_valid), 8'd1);
        checkOutput("basic_inp", 8'(net_inp), 8'hA);
        checkOutput("basic_err", 8'(err), 8'd0);
        checkOutput("basic_src_ready_low", 8'(src_ready), 8'd0);
        step();
        checkOutput("basic_src_ready_back", 8'(src_ready), 8'd1);
        checkOutput("basic_valid_drop", 8'(net_valid), 8'd0);
        checkOutput("basic_inp_clear", 8'(net_inp), 8'h0);

        // Empty run, then back-to-back run 1,0.
        applyStimulus(3'd0);
        checkOutput("empty_valid", 8'(net_valid), 8'd1);
        checkOutput("empty_inp", 8'(net_inp), 8'h0);
        step();
        applyStimulus(3'd1);
        applyStimulus(3'd0);
        checkOutput("b2b_valid", 8'(net_valid), 8'd1);
        checkOutput("b2b_inp", 8'(net_inp), 8'h1);
        step();

        // Backpressure: vector must hold while the network stalls.
        net_ready = 1'b0;
        applyStimulus(3'd1);
        applyStimulus(3'd2);
        src_valid = 1'b1;
        src       = 3'd3;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 8'(net_valid), 8'd1);
            checkOutput("bp_inp", 8'(net_inp), 8'h4);
            checkOutput("bp_src_ready", 8'(src_ready), 8'd0);
            step();
        end
        src_valid = 1'b0;
        src       = '0;
        net_ready = 1'b1;
        step();
        checkOutput("bp_release_src_ready", 8'(src_ready), 8'd1);
        checkOutput("bp_release_valid", 8'(net_valid), 8'd0);

        // Out-of-range index: flagged, vector untouched, error sticks.
        applyStimulus(3'd1);
        applyStimulus(3'd5);
        checkOutput("badidx_err", 8'(err), 8'd1);
        checkOutput("badidx_valid", 8'(net_valid), 8'd1);
        checkOutput("badidx_inp", 8'(net_inp), 8'h0);
        step();
        applyStimulus(3'd1);
        applyStimulus(3'd2);
        checkOutput("clean_after_err_inp", 8'(net_inp), 8'h4);
        checkOutput("err_sticky", 8'(err), 8'd1);
        step();

        // Oversized count saturates to NUM_INP index beats.
        applyStimulus(3'd7);
        checkOutput("bigcnt_err", 8'(err), 8'd1);
        applyStimulus(3'd0);
        applyStimulus(3'd1);
        applyStimulus(3'd2);
        checkOutput("bigcnt_not_yet_valid", 8'(net_valid), 8'd0);
        applyStimulus(3'd3);
        checkOutput("bigcnt_valid", 8'(net_valid), 8'd1);
        checkOutput("bigcnt_inp", 8'(net_inp), 8'hF);
        step();
        applyStimulus(3'd1);
        checkOutput("fifth_is_count", 8'(net_valid), 8'd0);
        applyStimulus(3'd0);
        checkOutput("fifth_run_valid", 8'(net_valid), 8'd1);
        checkOutput("fifth_run_inp", 8'(net_inp), 8'h1);
        step();

        // Only reset clears the error flag.
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("err_cleared", 8'(err), 8'd0);

        // Duplicate indices OR together without error.
        applyStimulus(3'd2);
        applyStimulus(3'd0);
        applyStimulus(3'd0);
        checkOutput("dup_valid", 8'(net_valid), 8'd1);
        checkOutput("dup_inp", 8'(net_inp), 8'h1);
        checkOutput("dup_err", 8'(err), 8'd0);
        step();

        // Reset mid-collect discards the partial vector.
        applyStimulus(3'd3);
        applyStimulus(3'd2);
        checkOutput("midrst_partial", 8'(net_inp), 8'h4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_src_ready", 8'(src_ready), 8'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("midrst_inp", 8'(net_inp), 8'h0);
        checkOutput("midrst_valid", 8'(net_valid), 8'd0);
        step();
        checkOutput("midrst_valid_later", 8'(net_valid), 8'd0);
        applyStimulus(3'd1);
        applyStimulus(3'd3);
        checkOutput("after_rst_valid", 8'(net_valid), 8'd1);
        checkOutput("after_rst_inp", 8'(net_inp), 8'h8);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
